arbitro_lcd: RTL and testbench

Round-robin arbiter and sequencer that shares the LCD executor's control/data register pair between two command requesters (e.g. a boot-time init sequencer and the CPU-side text writer). It owns the write ports into the control and data registers, starts one command at a time by setting EXEC, polls for completion via the done bit, and returns the read-back data word to the requester that issued it. It sits between the requesters and the register file that feeds `Ejecutador`.

---
 rtl/arbitro_lcd.sv | 200 ++++++++++++++++++++
 tb/tb_arbitro_lcd.sv | 533 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_lcd.sv
// arbitro_lcd: round-robin arbiter that sequences commands from two requesters into the LCD executor's registers.
// Optional watchdog: define ARBITRO_TIMEOUT_EN to abort a command after TIMEOUT_CICLOS cycles without done.
module arbitro_lcd #(
    parameter int unsigned TIMEOUT_CICLOS = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_0,
    input  logic        i_req_1,
    input  logic [31:0] i_ctrl_0,
    input  logic [31:0] i_ctrl_1,
    input  logic [31:0] i_dato_0,
    input  logic [31:0] i_dato_1,
    output logic        o_gnt_0,
    output logic        o_gnt_1,
    output logic        o_done_0,
    output logic        o_done_1,
    output logic        o_err_0,
    output logic        o_err_1,
    output logic [31:0] o_dato,
    input  logic [31:0] i_reg_control,
    input  logic [31:0] i_reg_datos,
    output logic        o_wr_reg_control,
    output logic        o_wr_reg_datos,
    output logic [31:0] o_in_reg_control,
    output logic [31:0] o_in_reg_datos,
    output logic        o_ocupado
);
    typedef enum logic [2:0] {INACTIVO, ESCRIBIR, ASENTAR, ESPERAR, RESPONDER} estado_t;

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CICLOS - 1);

    estado_t     estado_q, estado_d;
    logic        ult_q, ult_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] dato_q, dato_d;
    logic        gnt_0_q, gnt_0_d, gnt_1_q, gnt_1_d;
    logic        done_0_q, done_0_d, done_1_q, done_1_d;
    logic [31:0] res_q, res_d;
    logic        wr_ctrl_q, wr_ctrl_d, wr_dato_q, wr_dato_d;
    logic [31:0] in_ctrl_q, in_ctrl_d;
    logic [31:0] in_dato_q, in_dato_d;
    logic        ocupado_q, ocupado_d;
    logic        pick_0, pick_1, exec_fin;
`ifdef ARBITRO_TIMEOUT_EN
    logic        err_0_q, err_0_d, err_1_q, err_1_d;
    logic [31:0] cnt_q, cnt_d;
`endif
    logic        unused_bits;

    // Under contention the requester that was not served last wins; ult_q also names the current owner.
    assign pick_0   = i_req_0 && (!i_req_1 || ult_q);
    assign pick_1   = i_req_1 && (!i_req_0 || !ult_q);
    assign exec_fin = i_reg_control[0] && !i_reg_control[1];

    always_comb begin
        estado_d  = estado_q;
        ult_d     = ult_q;
        ctrl_d    = ctrl_q;
        dato_d    = dato_q;
        gnt_0_d   = gnt_0_q;
        gnt_1_d   = gnt_1_q;
        done_0_d  = 1'b0;
        done_1_d  = 1'b0;
        res_d     = 32'h0;
        wr_ctrl_d = 1'b0;
        wr_dato_d = 1'b0;
        in_ctrl_d = in_ctrl_q;
        in_dato_d = in_dato_q;
`ifdef ARBITRO_TIMEOUT_EN
        err_0_d   = 1'b0;
        err_1_d   = 1'b0;
        cnt_d     = cnt_q;
`endif
        case (estado_q)
            INACTIVO: begin
                if (pick_0) begin
                    ult_d    = 1'b0;
                    ctrl_d   = i_ctrl_0;
                    dato_d   = i_dato_0;
                    gnt_0_d  = 1'b1;
                    estado_d = ESCRIBIR;
                end else if (pick_1) begin
                    ult_d    = 1'b1;
                    ctrl_d   = i_ctrl_1;
                    dato_d   = i_dato_1;
                    gnt_1_d  = 1'b1;
                    estado_d = ESCRIBIR;
                end
            end
            ESCRIBIR: begin
                wr_ctrl_d = 1'b1;
                wr_dato_d = 1'b1;
                in_ctrl_d = (ctrl_q & ~32'h3) | 32'h2;
                in_dato_d = dato_q;
                estado_d  = ASENTAR;
            end
            ASENTAR: begin
`ifdef ARBITRO_TIMEOUT_EN
                cnt_d    = 32'h0;
`endif
                estado_d = ESPERAR;
            end
            ESPERAR: begin
                if (exec_fin) begin
                    done_0_d = !ult_q;
                    done_1_d = ult_q;
                    res_d    = i_reg_datos;
                    estado_d = RESPONDER;
                end
`ifdef ARBITRO_TIMEOUT_EN
                // Give up: report the error and drop EXEC so the executor is left idle.
                else if (cnt_q == TIMEOUT_LIM) begin
                    done_0_d  = !ult_q;
                    done_1_d  = ult_q;
                    err_0_d   = !ult_q;
                    err_1_d   = ult_q;
                    wr_ctrl_d = 1'b1;
                    in_ctrl_d = ctrl_q & ~32'h3;
                    estado_d  = RESPONDER;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            RESPONDER: begin
                gnt_0_d  = 1'b0;
                gnt_1_d  = 1'b0;
                estado_d = INACTIVO;
            end
            default: estado_d = INACTIVO;
        endcase
        ocupado_d = (estado_d != INACTIVO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= INACTIVO;
            ult_q     <= 1'b1;
            ctrl_q    <= 32'h0;
            dato_q    <= 32'h0;
            gnt_0_q   <= 1'b0;
            gnt_1_q   <= 1'b0;
            done_0_q  <= 1'b0;
            done_1_q  <= 1'b0;
            res_q     <= 32'h0;
            wr_ctrl_q <= 1'b0;
            wr_dato_q <= 1'b0;
            in_ctrl_q <= 32'h0;
            in_dato_q <= 32'h0;
            ocupado_q <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
            err_0_q   <= 1'b0;
            err_1_q   <= 1'b0;
            cnt_q     <= 32'h0;
`endif
        end else begin
            estado_q  <= estado_d;
            ult_q     <= ult_d;
            ctrl_q    <= ctrl_d;
            dato_q    <= dato_d;
            gnt_0_q   <= gnt_0_d;
            gnt_1_q   <= gnt_1_d;
            done_0_q  <= done_0_d;
            done_1_q  <= done_1_d;
            res_q     <= res_d;
            wr_ctrl_q <= wr_ctrl_d;
            wr_dato_q <= wr_dato_d;
            in_ctrl_q <= in_ctrl_d;
            in_dato_q <= in_dato_d;
            ocupado_q <= ocupado_d;
`ifdef ARBITRO_TIMEOUT_EN
            err_0_q   <= err_0_d;
            err_1_q   <= err_1_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign o_gnt_0          = gnt_0_q;
    assign o_gnt_1          = gnt_1_q;
    assign o_done_0         = done_0_q;
    assign o_done_1         = done_1_q;
    assign o_dato           = res_q;
    assign o_wr_reg_control = wr_ctrl_q;
    assign o_wr_reg_datos   = wr_dato_q;
    assign o_in_reg_control = in_ctrl_q;
    assign o_in_reg_datos   = in_dato_q;
    assign o_ocupado        = ocupado_q;
`ifdef ARBITRO_TIMEOUT_EN
    assign o_err_0     = err_0_q;
    assign o_err_1     = err_1_q;
    assign unused_bits = ^i_reg_control[31:2];
`else
    assign o_err_0     = 1'b0;
    assign o_err_1     = 1'b0;
    assign unused_bits = ^{i_reg_control[31:2], TIMEOUT_LIM};
`endif

endmodule

// File: tb/tb_arbitro_lcd.sv
// Self-checking bench for arbitro_lcd with a behavioural register-file/executor model and a response scoreboard.
`timescale 1ns/1ps
module tb_arbitro_lcd;
    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req_0 = 1'b0, i_req_1 = 1'b0;
    logic [31:0] i_ctrl_0 = '0, i_ctrl_1 = '0, i_dato_0 = '0, i_dato_1 = '0;
    logic        o_gnt_0, o_gnt_1, o_done_0, o_done_1, o_err_0, o_err_1;
    logic [31:0] o_dato;
    logic        o_wr_reg_control, o_wr_reg_datos, o_ocupado;
    logic [31:0] o_in_reg_control, o_in_reg_datos;
    logic [31:0] reg_control = '0, reg_datos = '0;

    arbitro_lcd #(.TIMEOUT_CICLOS(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req_0(i_req_0), .i_req_1(i_req_1),
        .i_ctrl_0(i_ctrl_0), .i_ctrl_1(i_ctrl_1),
        .i_dato_0(i_dato_0), .i_dato_1(i_dato_1),
        .o_gnt_0(o_gnt_0), .o_gnt_1(o_gnt_1),
        .o_done_0(o_done_0), .o_done_1(o_done_1),
        .o_err_0(o_err_0), .o_err_1(o_err_1),
        .o_dato(o_dato),
        .i_reg_control(reg_control), .i_reg_datos(reg_datos),
        .o_wr_reg_control(o_wr_reg_control), .o_wr_reg_datos(o_wr_reg_datos),
        .o_in_reg_control(o_in_reg_control), .o_in_reg_datos(o_in_reg_datos),
        .o_ocupado(o_ocupado)
    );

    initial forever #5 clk = ~clk;

    wire [104:0] all_outs = {o_gnt_0, o_gnt_1, o_done_0, o_done_1, o_err_0, o_err_1,
                             o_wr_reg_control, o_wr_reg_datos, o_ocupado,
                             o_dato, o_in_reg_control, o_in_reg_datos};

    // Register file plus executor: EXEC starts a countdown, completion clears EXEC and sets done.
    int          exec_lat   = 10;
    bit          exec_hang  = 1'b0;
    bit          exec_early = 1'b0;
    logic [31:0] exec_xor   = '0;
    logic [31:0] cmd_dato   = '0;
    int          exec_cnt   = 0;

    always @(posedge clk) begin
        if (o_wr_reg_datos) begin
            reg_datos <= o_in_reg_datos;
            cmd_dato  <= o_in_reg_datos;
        end
        if (o_wr_reg_control) begin
            reg_control <= o_in_reg_control;
            exec_cnt    <= 0;
        end else if (reg_control[1] && !exec_hang) begin
            exec_cnt <= exec_cnt + 1;
            if (exec_early && exec_cnt == exec_lat / 2) begin
                reg_control[0] <= 1'b1;
                reg_datos      <= 32'hDEAD_BEEF;
            end
            if (exec_cnt == exec_lat - 1) begin
                reg_control[1] <= 1'b0;
                reg_control[0] <= 1'b1;
                reg_datos      <= cmd_dato ^ exec_xor;
            end
        end
    end

    typedef struct {
        logic [1:0]  done;
        logic [1:0]  err;
        logic [31:0] dato;
    } resp_t;

    resp_t       exp_q[$];
    resp_t       done_log[$];
    logic [31:0] wr_ctrl_log[$];
    logic [31:0] wr_dato_log[$];
    int          gnt_log[$];
    int          overlap_cnt = 0;
    int          strobe_cnt  = 0;
    logic        prev_g0 = 1'b0, prev_g1 = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(negedge clk) begin : monitor
        resp_t r;
        if (o_gnt_0 && o_gnt_1) overlap_cnt++;
        if (o_gnt_0 && !prev_g0) gnt_log.push_back(0);
        if (o_gnt_1 && !prev_g1) gnt_log.push_back(1);
        prev_g0 = o_gnt_0;
        prev_g1 = o_gnt_1;
        if (o_wr_reg_control) begin
            wr_ctrl_log.push_back(o_in_reg_control);
            strobe_cnt++;
        end
        if (o_wr_reg_datos) wr_dato_log.push_back(o_in_reg_datos);
        if (o_done_0 || o_done_1 || o_err_0 || o_err_1) begin
            r.done = {o_done_1, o_done_0};
            r.err  = {o_err_1, o_err_0};
            r.dato = o_dato;
            done_log.push_back(r);
        end
    end

    task automatic clear_logs;
        exp_q.delete();
        done_log.delete();
        wr_ctrl_log.delete();
        wr_dato_log.delete();
        gnt_log.delete();
        overlap_cnt = 0;
        strobe_cnt  = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (o_done_0 || o_done_1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (all_outs !== 105'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_outs: got %h, expected 0", all_outs);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (all_outs !== 105'd0) begin
            n_bad++;
            $display("[TB] FAIL idle_outs: got %h, expected 0", all_outs);
        end
    endtask

    task automatic test_single;
        resp_t e, o;
        bit    ok;
        clear_logs();
        exec_lat = 50; exec_xor = '0; exec_early = 1'b0; exec_hang = 1'b0;
        @(negedge clk);
        i_ctrl_0 = 32'h0000_0010; i_dato_0 = 32'h41; i_req_0 = 1'b1;
        e.done = 2'b01; e.err = 2'b00; e.dato = 32'h41;
        exp_q.push_back(e);
        @(negedge clk);
        n_cmp++;
        if ({o_gnt_0, o_gnt_1, o_ocupado, o_wr_reg_control} !== 4'b1010) begin
            n_bad++;
            $display("[TB] FAIL grant_timing: got gnt0/gnt1/busy/wr=%b, expected 1010",
                     {o_gnt_0, o_gnt_1, o_ocupado, o_wr_reg_control});
        end
        @(negedge clk);
        n_cmp++;
        if ({o_wr_reg_control, o_wr_reg_datos} !== 2'b11) begin
            n_bad++;
            $display("[TB] FAIL strobe_high: got %b, expected 11", {o_wr_reg_control, o_wr_reg_datos});
        end
        @(negedge clk);
        n_cmp++;
        if ({o_wr_reg_control, o_wr_reg_datos} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL strobe_low: got %b, expected 00", {o_wr_reg_control, o_wr_reg_datos});
        end
        wait_done(300, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL single_done_seen: got %b, expected 1", ok);
        end
        i_req_0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_done_0, o_gnt_0, o_ocupado, o_dato} !== 35'd0) begin
            n_bad++;
            $display("[TB] FAIL single_release: got %h, expected 0", {o_done_0, o_gnt_0, o_ocupado, o_dato});
        end
        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (done_log.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL single_resp: got no response, expected dato %h", e.dato);
            end else begin
                o = done_log.pop_front();
                if ({o.done, o.err, o.dato} !== {e.done, e.err, e.dato}) begin
                    n_bad++;
                    $display("[TB] FAIL single_resp: got done=%b err=%b dato=%h, expected done=%b err=%b dato=%h",
                             o.done, o.err, o.dato, e.done, e.err, e.dato);
                end
            end
        end
        n_cmp++;
        if (done_log.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL single_extra_done: got %0d extra pulses, expected 0", done_log.size());
        end
        n_cmp++;
        if (wr_ctrl_log.size() != 1 || wr_ctrl_log[0] !== 32'h12 || wr_dato_log.size() != 1 || wr_dato_log[0] !== 32'h41) begin
            n_bad++;
            $display("[TB] FAIL single_write: got %0d ctrl writes (first %h) %0d data writes, expected one write of 12/41",
                     wr_ctrl_log.size(), (wr_ctrl_log.size() > 0) ? wr_ctrl_log[0] : 32'h0, wr_dato_log.size());
        end
        n_cmp++;
        if (gnt_log.size() != 1 || gnt_log[0] != 0) begin
            n_bad++;
            $display("[TB] FAIL single_gnt: got %0d grants, expected exactly one to requester 0", gnt_log.size());
        end
    endtask

    task automatic test_read_early_done;
        resp_t e, o;
        bit    ok;
        clear_logs();
        exec_lat = 40; exec_xor = 32'h80; exec_early = 1'b1; exec_hang = 1'b0;
        @(negedge clk);
        i_ctrl_1 = 32'h0000_0107; i_dato_1 = 32'h0; i_req_1 = 1'b1;
        e.done = 2'b10; e.err = 2'b00; e.dato = 32'h80;
        exp_q.push_back(e);
        wait_done(300, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL read_done_seen: got %b, expected 1", ok);
        end
        i_req_1 = 1'b0;
        repeat (20) @(negedge clk);
        exec_early = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (done_log.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL read_resp: got no response, expected dato %h", e.dato);
            end else begin
                o = done_log.pop_front();
                if ({o.done, o.err, o.dato} !== {e.done, e.err, e.dato}) begin
                    n_bad++;
                    $display("[TB] FAIL read_resp: got done=%b err=%b dato=%h, expected done=%b err=%b dato=%h",
                             o.done, o.err, o.dato, e.done, e.err, e.dato);
                end
            end
        end
        n_cmp++;
        if (done_log.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL read_extra_done: got %0d extra pulses, expected 0", done_log.size());
        end
        n_cmp++;
        if (wr_ctrl_log.size() != 1 || wr_ctrl_log[0] !== 32'h106) begin
            n_bad++;
            $display("[TB] FAIL read_ctrl_write: got %0d writes (first %h), expected one of 106",
                     wr_ctrl_log.size(), (wr_ctrl_log.size() > 0) ? wr_ctrl_log[0] : 32'h0);
        end
    endtask

    task automatic test_back_to_back;
        resp_t e, o;
        int    c0, c1, cyc;
        clear_logs();
        exec_lat = 10; exec_xor = 32'h5A5A_0000; exec_early = 1'b0; exec_hang = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        i_ctrl_0 = 32'h10; i_dato_0 = 32'h100; i_req_0 = 1'b1;
        i_ctrl_1 = 32'h20; i_dato_1 = 32'h200; i_req_1 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            e.err = 2'b00;
            e.done = 2'b01; e.dato = (32'h100 + 32'(j)) ^ exec_xor; exp_q.push_back(e);
            e.done = 2'b10; e.dato = (32'h200 + 32'(j)) ^ exec_xor; exp_q.push_back(e);
        end
        repeat (2) @(negedge clk);
        clear_logs_keep_exp();
        rst = 1'b0;
        c0 = 0; c1 = 0; cyc = 0;
        while ((c0 < 3 || c1 < 3) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (o_done_0) begin
                c0++;
                if (c0 == 3) i_req_0 = 1'b0;
                else begin
                    i_ctrl_0 = 32'h10 * 32'(c0 + 1);
                    i_dato_0 = 32'h100 + 32'(c0);
                end
            end
            if (o_done_1) begin
                c1++;
                if (c1 == 3) i_req_1 = 1'b0;
                else begin
                    i_ctrl_1 = 32'h20 * 32'(c1 + 1);
                    i_dato_1 = 32'h200 + 32'(c1);
                end
            end
        end
        i_req_0 = 1'b0; i_req_1 = 1'b0;
        n_cmp++;
        if (c0 != 3 || c1 != 3) begin
            n_bad++;
            $display("[TB] FAIL b2b_completed: got %0d/%0d commands, expected 3/3", c0, c1);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (gnt_log.size() != 6) begin
            n_bad++;
            $display("[TB] FAIL b2b_gnt_count: got %0d, expected 6", gnt_log.size());
        end
        for (int i = 0; i < gnt_log.size() && i < 6; i++) begin
            n_cmp++;
            if (gnt_log[i] != (i % 2)) begin
                n_bad++;
                $display("[TB] FAIL b2b_gnt_order[%0d]: got %0d, expected %0d", i, gnt_log[i], i % 2);
            end
        end
        n_cmp++;
        if (overlap_cnt != 0) begin
            n_bad++;
            $display("[TB] FAIL b2b_overlap: got %0d cycles with both grants, expected 0", overlap_cnt);
        end
        n_cmp++;
        if (strobe_cnt != 6) begin
            n_bad++;
            $display("[TB] FAIL b2b_strobes: got %0d, expected 6", strobe_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (done_log.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL b2b_resp: got no response, expected done=%b dato=%h", e.done, e.dato);
            end else begin
                o = done_log.pop_front();
                if ({o.done, o.err, o.dato} !== {e.done, e.err, e.dato}) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_resp: got done=%b err=%b dato=%h, expected done=%b err=%b dato=%h",
                             o.done, o.err, o.dato, e.done, e.err, e.dato);
                end
            end
        end
        n_cmp++;
        if (done_log.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL b2b_extra_done: got %0d extra pulses, expected 0", done_log.size());
        end
    endtask

    task automatic clear_logs_keep_exp;
        done_log.delete();
        wr_ctrl_log.delete();
        wr_dato_log.delete();
        gnt_log.delete();
        overlap_cnt = 0;
        strobe_cnt  = 0;
    endtask

    task automatic test_reset_mid_command;
        resp_t e, o;
        bit    ok;
        clear_logs();
        exec_hang = 1'b1; exec_xor = '0;
        @(negedge clk);
        i_ctrl_0 = 32'h44; i_dato_0 = 32'h55; i_req_0 = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if ({o_gnt_0, o_ocupado} !== 2'b11) begin
            n_bad++;
            $display("[TB] FAIL midcmd_waiting: got gnt0/busy=%b, expected 11", {o_gnt_0, o_ocupado});
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (all_outs !== 105'd0) begin
            n_bad++;
            $display("[TB] FAIL midcmd_reset_outs: got %h, expected 0", all_outs);
        end
        i_req_0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        exec_hang = 1'b0; exec_lat = 8;
        @(negedge clk);
        i_ctrl_1 = 32'h20; i_dato_1 = 32'h33; i_req_1 = 1'b1;
        e.done = 2'b10; e.err = 2'b00; e.dato = 32'h33;
        exp_q.push_back(e);
        wait_done(200, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL midcmd_fresh_done: got %b, expected 1", ok);
        end
        i_req_1 = 1'b0;
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (done_log.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL midcmd_resp: got no response, expected dato %h", e.dato);
            end else begin
                o = done_log.pop_front();
                if ({o.done, o.err, o.dato} !== {e.done, e.err, e.dato}) begin
                    n_bad++;
                    $display("[TB] FAIL midcmd_resp: got done=%b err=%b dato=%h, expected done=%b err=%b dato=%h",
                             o.done, o.err, o.dato, e.done, e.err, e.dato);
                end
            end
        end
        n_cmp++;
        if (wr_ctrl_log.size() != 1 || wr_ctrl_log[0] !== 32'h22) begin
            n_bad++;
            $display("[TB] FAIL midcmd_fresh_write: got %0d writes (first %h), expected one of 22",
                     wr_ctrl_log.size(), (wr_ctrl_log.size() > 0) ? wr_ctrl_log[0] : 32'h0);
        end
    endtask

`ifdef ARBITRO_TIMEOUT_EN
    task automatic test_timeout;
        resp_t e, o;
        int    cyc;
        bit    got;
        clear_logs();
        exec_hang = 1'b1;
        @(negedge clk);
        i_ctrl_0 = 32'h31; i_dato_0 = 32'h7; i_req_0 = 1'b1;
        e.done = 2'b01; e.err = 2'b01; e.dato = 32'h0;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (o_wr_reg_control) got = 1'b1;
        end
        n_cmp++;
        if (got !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL timeout_strobe_seen: got %b, expected 1", got);
        end
        // The next edge enters ESPERAR; count cycles from there.
        @(negedge clk);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (o_done_0 || o_done_1) got = 1'b1;
        end
        n_cmp++;
        if (cyc != int'(TO)) begin
            n_bad++;
            $display("[TB] FAIL timeout_latency: got %0d cycles, expected %0d", cyc, TO);
        end
        n_cmp++;
        if ({o_wr_reg_control, o_wr_reg_datos, o_in_reg_control} !== {1'b1, 1'b0, 32'h30}) begin
            n_bad++;
            $display("[TB] FAIL timeout_ctrl_rewrite: got wr=%b%b ctrl=%h, expected wr=10 ctrl=30",
                     o_wr_reg_control, o_wr_reg_datos, o_in_reg_control);
        end
        i_req_0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_done_0, o_err_0, o_wr_reg_control, o_gnt_0} !== 4'b0000) begin
            n_bad++;
            $display("[TB] FAIL timeout_release: got %b, expected 0000",
                     {o_done_0, o_err_0, o_wr_reg_control, o_gnt_0});
        end
        repeat (5) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (done_log.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL timeout_resp: got no response, expected err pulse");
            end else begin
                o = done_log.pop_front();
                if ({o.done, o.err, o.dato} !== {e.done, e.err, e.dato}) begin
                    n_bad++;
                    $display("[TB] FAIL timeout_resp: got done=%b err=%b dato=%h, expected done=%b err=%b dato=%h",
                             o.done, o.err, o.dato, e.done, e.err, e.dato);
                end
            end
        end
        exec_hang = 1'b0;
    endtask
`else
    task automatic test_no_timeout;
        clear_logs();
        exec_hang = 1'b1;
        @(negedge clk);
        i_ctrl_0 = 32'h31; i_dato_0 = 32'h7; i_req_0 = 1'b1;
        repeat (10000) @(negedge clk);
        n_cmp++;
        if (done_log.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL no_timeout_pulse: got %0d pulses, expected 0", done_log.size());
        end
        n_cmp++;
        if ({o_gnt_0, o_ocupado} !== 2'b11) begin
            n_bad++;
            $display("[TB] FAIL no_timeout_still_waiting: got gnt0/busy=%b, expected 11", {o_gnt_0, o_ocupado});
        end
        i_req_0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exec_hang = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        test_reset();
        test_single();
        test_read_early_done();
        test_back_to_back();
        test_reset_mid_command();
`ifdef ARBITRO_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
